// File: rtl/seq_pattern_tx_if.sv
// Handshake/bus bundle between a pattern source and seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             data_out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n,
    input  data_out, valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n,
    output data_out, valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first,
// repeat_n+1 back-to-back passes, with busy/valid while shifting and a
// one-cycle done pulse afterwards.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_pattern_tx_if.slave bus
);

  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic [CNT_W-1:0] r_pass;
  logic             r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pat_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [CNT_W-1:0] w_pass_nxt;
  logic             w_data_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // State, datapath and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_pass    <= '0;
      r_data    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_pass    <= w_pass_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; outputs default to the idle value 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_pass_nxt    = r_pass;
    w_data_nxt    = 1'b0;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // abort masks start, so a simultaneous request never launches.
        if (bus.start && !bus.abort) begin
          w_state_nxt   = ST_SHIFT;
          w_pat_nxt     = bus.pattern;
          w_shift_nxt   = bus.pattern;
          w_pass_nxt    = bus.repeat_n;
          w_bit_cnt_nxt = '0;
          w_data_nxt    = bus.pattern[WIDTH-1];
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          // Drop the partial pass silently: no done pulse.
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
          w_pass_nxt    = '0;
        end else if (r_bit_cnt == LAST_BIT) begin
          if (r_pass != '0) begin
            // Next pass starts on the very next cycle, no gap bit.
            w_pass_nxt    = r_pass - CNT_W'(1);
            w_shift_nxt   = r_pat;
            w_bit_cnt_nxt = '0;
            w_data_nxt    = r_pat[WIDTH-1];
            w_valid_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
          end else begin
            w_state_nxt   = ST_DONE;
            w_bit_cnt_nxt = '0;
            w_done_nxt    = 1'b1;
          end
        end else begin
          w_shift_nxt   = r_shift << 1;
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          w_data_nxt    = r_shift[WIDTH-2];
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end

      ST_DONE: begin
        // start and abort are both ignored for this single cycle.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus randomized transfers,
// each output cycle compared against a stream model built from the
// pattern/pass/abort parameters of the transfer.
module tb_seq_pattern_tx;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {data_out, valid, busy, done} against the expected vector.
  task automatic check(input string tag, input int k, input logic [3:0] exp);
    logic [3:0] got;
    got = {bus.data_out, bus.valid, bus.busy, bus.done};
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s k=%0d: observed {data,valid,busy,done}=%b expected %b", tag, k, got, exp);
    end
  endtask

  // Expected outputs k cycles after the accepting edge: the pattern repeated
  // 'passes' times MSB first, then one done cycle, then silence; an abort
  // sampled at edge k silences everything from cycle k on.
  function automatic logic [3:0] model(input logic [WIDTH-1:0] pat, input int passes,
                                       input int k, input int abort_k);
    int total;
    int idx;
    total = passes * int'(WIDTH);
    if (abort_k >= 0 && k >= abort_k) return 4'b0000;
    if (k < total) begin
      idx = int'(WIDTH) - 1 - (k % int'(WIDTH));
      return {pat[idx], 3'b110};
    end
    if (k == total) return 4'b0001;
    return 4'b0000;
  endfunction

  // Called in cycle N (just after the accepting edge). Checks the whole
  // transfer while scribbling on pattern/repeat_n and firing stray start
  // pulses that must be ignored. With chain set, start is raised in the DONE
  // cycle and held so the next transfer is accepted at the first IDLE edge.
  task automatic body(input string tag, input logic [WIDTH-1:0] pat, input int rep,
                      input int abort_k, input bit chain,
                      input logic [WIDTH-1:0] npat, input int nrep);
    int passes;
    int total;
    int stop;
    passes = rep + 1;
    total  = passes * int'(WIDTH);
    stop   = (abort_k >= 0) ? abort_k : total + 1;
    for (int k = 0; k <= stop; k++) begin
      check(tag, k, model(pat, passes, k, abort_k));
      bus.pattern  = WIDTH'($urandom);
      bus.repeat_n = CNT_W'($urandom);
      if (chain && k >= total) begin
        bus.start    = 1'b1;
        bus.pattern  = npat;
        bus.repeat_n = CNT_W'(nrep);
      end else if (k < stop) begin
        bus.start = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (abort_k >= 0) bus.abort = (k + 1 == abort_k);
      else              bus.abort = (k == total) ? 1'($urandom) : 1'b0;
      if (k < stop) tick();
    end
    if (!chain) begin
      tick();
      check({tag, "_idle"}, stop + 1, model(pat, passes, stop + 1, abort_k));
    end
  endtask

  // Launch one transfer from IDLE and check it to completion.
  task automatic xfer(input string tag, input logic [WIDTH-1:0] pat, input int rep,
                      input int abort_k);
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.pattern  = pat;
    bus.repeat_n = CNT_W'(rep);
    tick();
    bus.start = 1'b0;
    body(tag, pat, rep, abort_k, 1'b0, '0, 0);
    bus.abort = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    int               r;
    int               a;

    // Reset held two cycles with start high: everything stays quiet.
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.pattern  = 4'b0110;
    bus.repeat_n = '0;
    tick();
    check("rst_c0", 0, 4'b0000);
    tick();
    check("rst_c1", 1, 4'b0000);
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", i, 4'b0000);
    end

    // Single pass and repeated passes of 0110.
    xfer("single", 4'b0110, 0, -1);
    xfer("repeat3", 4'b0110, 2, -1);

    // Abort at edge N+5 of a two-pass 1011 transfer.
    xfer("abort", 4'b1011, 1, 5);

    // start and abort together in IDLE: nothing launches.
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.pattern = 4'b1111;
    tick();
    check("start_abort", 0, 4'b0000);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    check("start_abort", 1, 4'b0000);

    // Reset at edge N+2 of a running transfer: silence, no done pulse.
    bus.start    = 1'b1;
    bus.pattern  = 4'b0110;
    bus.repeat_n = CNT_W'(3);
    tick();
    bus.start = 1'b0;
    check("mid_rst", 0, model(4'b0110, 4, 0, -1));
    tick();
    check("mid_rst", 1, model(4'b0110, 4, 1, -1));
    rst = 1'b1;
    tick();
    check("mid_rst", 2, 4'b0000);
    rst = 1'b0;
    for (int i = 3; i < 7; i++) begin
      tick();
      check("mid_rst", i, 4'b0000);
    end

    // Back-to-back: start raised in DONE and held, accepted after one IDLE cycle.
    bus.start    = 1'b1;
    bus.pattern  = 4'b1001;
    bus.repeat_n = '0;
    tick();
    body("b2b_first", 4'b1001, 0, -1, 1'b1, 4'b0111, 1);
    tick();
    bus.start = 1'b0;
    body("b2b_second", 4'b0111, 1, -1, 1'b0, '0, 0);
    bus.abort = 1'b0;

    // Maximum repeat count: 2^CNT_W passes.
    xfer("max_rep", WIDTH'($urandom), int'({CNT_W{1'b1}}), -1);

    // Randomized transfers, some aborted, separated by random idle gaps.
    for (int t = 0; t < 24; t++) begin
      p = WIDTH'($urandom);
      r = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (r + 1) * WIDTH)) : -1;
      xfer("rand", p, r, a);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        check("rand_gap", g, 4'b0000);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
